snake_head_mover: RTL and testbench
===================================

# snake_head_mover

Consumes the one-hot `direction` bus produced by the button-input stage and advances the snake head across the playfield grid at a fixed game-tick rate. Rejects 180° reversals and malformed direction codes. Emits the head coordinates, the committed heading and a one-cycle `step` pulse for the body/collision/render logic downstream. Edge behaviour is selectable: wrap-around, or game over at the wall.

## Interface
- `GRID_W`, 40, grid width in cells.
- `GRID_H`, 30, grid height in cells.
- `XW`, 6, width of `head_x`; must hold GRID_W-1.
- `YW`, 5, width of `head_y`; must hold GRID_H-1.
- `TICK_DIV`, 5000000, clk cycles per head step; must be ≥2.
- `START_X`, 20, head x after reset.
- `START_Y`, 15, head y after reset.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `direction`  in  4  one-hot request: 0001 left, 0010 right, 0100 up, 1000 down.
- `enable`  in  1  1 = game running; 0 = pause.
- `head_x`  out  XW  head column; 0 = leftmost.
- `head_y`  out  YW  head row; 0 = top.
- `heading`  out  4  direction used for the last step; 0000 before the first step.
- `step`  out  1  one-cycle pulse; high in the cycle after the edge that moved the head.
- `game_over`  out  1  sticky wall-hit flag; only set when WRAP_EN is undefined.

## Operation
- Reset: head_x=START_X, head_y=START_Y, heading=0000, pending=0000, tick counter=0, step=0, game_over=0, state IDLE.
- Valid code: exactly one bit set. 0000 and multi-bit codes are ignored every cycle.
- States:
  - IDLE: counter held at 0. On the first valid code while enable=1, pending←code and go to RUN. Any of the four codes is accepted.
  - RUN: counter increments on each enable=1 cycle. enable=0 freezes the counter and position.
    - Each cycle, a valid code that is not opposite to `heading` is loaded into pending. Opposite pairs: 0001/0010 and 0100/1000.
    - The check is against `heading`, not against pending. So two quick turns within one tick can never produce a reversal.
    - When counter==TICK_DIV-1 and enable=1: counter←0, heading←pending, head moves one cell per pending, step=1.
    - Moves: left x-1, right x+1, up y-1, down y+1.
  - DEAD: only without WRAP_EN. game_over=1. Position, heading and counter frozen. Exit only via rst.
- Tick cycle collision: the step uses pending as registered before that edge. A code arriving on the tick cycle updates pending at the same edge and applies to the next step. It is still checked against the pre-edge heading.
- step is 0 in every cycle other than the one following a move.

## Timing
- direction → pending: 1 cycle.
- First step: TICK_DIV edges after the IDLE→RUN edge, when enable stays high.
- Step period: exactly TICK_DIV cycles of enable=1. Paused cycles stretch the period and are not counted.
- Async rst mid-step: all outputs return to reset values immediately. No partial move survives.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - left at x=0 → x=GRID_W-1; right at x=GRID_W-1 → x=0.
  - up at y=0 → y=GRID_H-1; down at y=GRID_H-1 → y=0.
  - step pulses normally. game_over tied 0. DEAD unreachable.
- `SNAKE_WRAP_EN` undefined:
  - a step that would leave the grid leaves coordinates unchanged, commits heading, keeps step=0, sets game_over=1 and enters DEAD, all at that edge.

## Test plan
Bench parameters: GRID_W=8, GRID_H=8, XW=3, YW=3, TICK_DIV=4, START=(4,4).
- Reset, then direction=0010 with enable=1 → pending=0010 after 1 edge. step pulses every 4 cycles. head_x goes 5, 6, 7; heading=0010.
- Heading 0010, apply 0001 for 3 cycles then 0100 → reversal ignored. Next step moves up: y 4→3, heading=0100.
- direction=0011, then 0000, while in IDLE → stays in IDLE, no step, head stays at (4,4).
- enable=0 for 10 cycles mid-tick → no step and no counter advance. The step lands exactly at the remaining count after enable returns to 1.
- With SNAKE_WRAP_EN, head at x=7 heading right → next step gives x=0 with step=1. Without the macro → x stays 7, game_over=1, step=0, and there are no further steps until rst.
- Assert rst on the cycle of a tick → (4,4), heading=0000, step=0 immediately. Block returns to IDLE.

Source files
------------

// File: rtl/snake_head_mover.sv
// snake_head_mover: moves the snake head one grid cell per game tick, steered by a one-hot direction.
// Define SNAKE_WRAP_EN to wrap at the edges; otherwise a wall hit sets game_over and stops the head.
module snake_head_mover #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned XW       = 6,
  parameter int unsigned YW       = 5,
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    direction,
  input  logic          enable,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [3:0]    heading,
  output logic          step,
  output logic          game_over
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  localparam logic [3:0] DirLeft  = 4'b0001;
  localparam logic [3:0] DirRight = 4'b0010;
  localparam logic [3:0] DirUp    = 4'b0100;
  localparam logic [3:0] DirDown  = 4'b1000;

  localparam logic [XW-1:0] XMax   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMax   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] XStart = XW'(START_X);
  localparam logic [YW-1:0] YStart = YW'(START_Y);
  localparam logic [CW-1:0] CntMax = CW'(TICK_DIV - 1);

`ifdef SNAKE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e        state_q;
  logic [3:0]    pending_q;
  logic [CW-1:0] cnt_q;

  logic          dir_valid;
  logic          dir_accept;
  logic [3:0]    opposite;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          at_wall;

  // Reversal check is against the committed heading, so quick double turns cannot reverse.
  always_comb begin
    dir_valid  = (direction != 4'b0000) && ((direction & (direction - 4'd1)) == 4'b0000);
    opposite   = {heading[2], heading[3], heading[0], heading[1]};
    dir_accept = dir_valid && (direction != opposite);
  end

  // Candidate position for the pending direction; at_wall flags a move that leaves the grid.
  always_comb begin
    next_x  = head_x;
    next_y  = head_y;
    at_wall = 1'b0;
    unique case (pending_q)
      DirLeft: begin
        if (head_x == '0) begin
          next_x  = XMax;
          at_wall = 1'b1;
        end else begin
          next_x = head_x - XW'(1);
        end
      end
      DirRight: begin
        if (head_x == XMax) begin
          next_x  = '0;
          at_wall = 1'b1;
        end else begin
          next_x = head_x + XW'(1);
        end
      end
      DirUp: begin
        if (head_y == '0) begin
          next_y  = YMax;
          at_wall = 1'b1;
        end else begin
          next_y = head_y - YW'(1);
        end
      end
      DirDown: begin
        if (head_y == YMax) begin
          next_y  = '0;
          at_wall = 1'b1;
        end else begin
          next_y = head_y + YW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      cnt_q     <= '0;
      head_x    <= XStart;
      head_y    <= YStart;
      heading   <= 4'b0000;
      step      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (enable && dir_valid) begin
            pending_q <= direction;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (dir_accept) begin
            pending_q <= direction;
          end
          if (enable) begin
            if (cnt_q == CntMax) begin
              cnt_q   <= '0;
              heading <= pending_q;
              if (at_wall && !WrapEn) begin
                game_over <= 1'b1;
                state_q   <= StDead;
              end else begin
                head_x <= next_x;
                head_y <= next_y;
                step   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        StDead: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_mover.sv
// Self-checking bench for snake_head_mover on an 8x8 grid with a 4-cycle tick, start (4,4).
module tb_snake_head_mover;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] hd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] direction = 4'b0000;
  logic       enable = 1'b0;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [3:0] heading;
  logic       step;
  logic       game_over;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  snake_head_mover #(
    .GRID_W  (8),
    .GRID_H  (8),
    .XW      (3),
    .YW      (3),
    .TICK_DIV(4),
    .START_X (4),
    .START_Y (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .direction(direction),
    .enable   (enable),
    .head_x   (head_x),
    .head_y   (head_y),
    .heading  (heading),
    .step     (step),
    .game_over(game_over)
  );

  function automatic exp_t mk(input int x, input int y, input logic [3:0] hd);
    exp_t e;
    e.x  = 3'(x);
    e.y  = 3'(y);
    e.hd = hd;
    return e;
  endfunction

  // Waits (sampling on falling edges) for a step pulse, at most budget cycles.
  task automatic wait_step(input int budget, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (step === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit saw;
    rst = 1'b1;
    enable = 1'b0;
    direction = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({head_x, head_y, heading, step, game_over} !== {3'd4, 3'd4, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d hd=%b step=%b go=%b, expected 4 4 0000 0 0",
               head_x, head_y, heading, step, game_over);
    end
    rst = 1'b0;
    direction = 4'b0010;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (step !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw || heading !== 4'b0000) begin
      errors++;
      $display("FAIL no_start_when_disabled: got step_seen=%b hd=%b, expected 0 0000", saw, heading);
    end
  endtask

  task automatic test_idle_ignore();
    logic [3:0] codes [3];
    bit saw;
    codes[0] = 4'b0011;
    codes[1] = 4'b1100;
    codes[2] = 4'b0000;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      direction = codes[i];
      saw = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (step !== 1'b0) saw = 1'b1;
      end
      checks++;
      if (saw || {head_x, head_y, heading} !== {3'd4, 3'd4, 4'b0000}) begin
        errors++;
        $display("FAIL idle_ignore_%b: got step_seen=%b x=%0d y=%0d hd=%b, expected 0 4 4 0000",
                 codes[i], saw, head_x, head_y, heading);
      end
    end
  endtask

  task automatic test_move_right();
    bit   found;
    int   cyc;
    exp_t e;
    direction = 4'b0010;
    sb.push_back(mk(5, 4, 4'b0010));
    sb.push_back(mk(6, 4, 4'b0010));
    for (int i = 0; i < 2; i++) begin
      wait_step(12, found, cyc);
      checks++;
      if (!found || cyc != (i == 0 ? 5 : 4)) begin
        errors++;
        $display("FAIL right_step_timing_%0d: got found=%b cycles=%0d, expected cycles=%0d",
                 i, found, cyc, (i == 0 ? 5 : 4));
      end
      e = sb.pop_front();
      checks++;
      if ({head_x, head_y, heading} !== e) begin
        errors++;
        $display("FAIL right_step_pos_%0d: got %0d,%0d,%b expected %0d,%0d,%b",
                 i, head_x, head_y, heading, e.x, e.y, e.hd);
      end
    end
  endtask

  // Left (reversal) held 3 cycles, then up on the tick cycle: tick goes right, next goes up.
  task automatic test_reversal();
    bit   found;
    int   cyc;
    exp_t e;
    direction = 4'b0001;
    sb.push_back(mk(7, 4, 4'b0010));
    sb.push_back(mk(7, 3, 4'b0100));
    repeat (3) @(negedge clk);
    direction = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      wait_step(12, found, cyc);
      direction = 4'b0000;
      checks++;
      if (!found || cyc != (i == 0 ? 1 : 4)) begin
        errors++;
        $display("FAIL reversal_timing_%0d: got found=%b cycles=%0d, expected cycles=%0d",
                 i, found, cyc, (i == 0 ? 1 : 4));
      end
      e = sb.pop_front();
      checks++;
      if ({head_x, head_y, heading} !== e) begin
        errors++;
        $display("FAIL reversal_pos_%0d: got %0d,%0d,%b expected %0d,%0d,%b",
                 i, head_x, head_y, heading, e.x, e.y, e.hd);
      end
    end
  endtask

  // Heading up, pending left; right arrives on the tick, judged against the old heading (up).
  task automatic test_tick_collision();
    bit   found;
    int   cyc;
    exp_t e;
    direction = 4'b0001;
    @(negedge clk);
    direction = 4'b0000;
    repeat (2) @(negedge clk);
    direction = 4'b0010;
    sb.push_back(mk(6, 3, 4'b0001));
    sb.push_back(mk(7, 3, 4'b0010));
    for (int i = 0; i < 2; i++) begin
      wait_step(12, found, cyc);
      direction = 4'b0000;
      checks++;
      if (!found || cyc != (i == 0 ? 1 : 4)) begin
        errors++;
        $display("FAIL collision_timing_%0d: got found=%b cycles=%0d, expected cycles=%0d",
                 i, found, cyc, (i == 0 ? 1 : 4));
      end
      e = sb.pop_front();
      checks++;
      if ({head_x, head_y, heading} !== e) begin
        errors++;
        $display("FAIL collision_pos_%0d: got %0d,%0d,%b expected %0d,%0d,%b",
                 i, head_x, head_y, heading, e.x, e.y, e.hd);
      end
    end
  endtask

  task automatic test_pause();
    bit   found;
    bit   saw;
    int   cyc;
    exp_t e;
    direction = 4'b0100;
    sb.push_back(mk(7, 2, 4'b0100));
    @(negedge clk);
    direction = 4'b0000;
    @(negedge clk);
    enable = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (step !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw || {head_x, head_y} !== {3'd7, 3'd3}) begin
      errors++;
      $display("FAIL pause_frozen: got step_seen=%b x=%0d y=%0d, expected 0 7 3", saw, head_x, head_y);
    end
    enable = 1'b1;
    wait_step(12, found, cyc);
    checks++;
    if (!found || cyc != 2) begin
      errors++;
      $display("FAIL pause_resume_timing: got found=%b cycles=%0d, expected cycles=2", found, cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({head_x, head_y, heading} !== e) begin
      errors++;
      $display("FAIL pause_pos: got %0d,%0d,%b expected %0d,%0d,%b",
               head_x, head_y, heading, e.x, e.y, e.hd);
    end
  endtask

  task automatic test_wall();
    bit   found;
    bit   saw;
    int   cyc;
    exp_t e;
    sb.push_back(mk(7, 1, 4'b0100));
    sb.push_back(mk(7, 0, 4'b0100));
`ifdef SNAKE_WRAP_EN
    sb.push_back(mk(7, 7, 4'b0100));
    sb.push_back(mk(0, 7, 4'b0010));
    for (int i = 0; i < 4; i++) begin
`else
    for (int i = 0; i < 2; i++) begin
`endif
      wait_step(12, found, cyc);
      direction = 4'b0000;
      checks++;
      if (!found || cyc != 4) begin
        errors++;
        $display("FAIL wall_timing_%0d: got found=%b cycles=%0d, expected cycles=4", i, found, cyc);
      end
      e = sb.pop_front();
      checks++;
      if ({head_x, head_y, heading, game_over} !== {e, 1'b0}) begin
        errors++;
        $display("FAIL wall_pos_%0d: got %0d,%0d,%b go=%b expected %0d,%0d,%b go=0",
                 i, head_x, head_y, heading, game_over, e.x, e.y, e.hd);
      end
      if (i == 2) direction = 4'b0010;
    end
`ifndef SNAKE_WRAP_EN
    repeat (4) @(negedge clk);
    checks++;
    if ({head_x, head_y, heading, step, game_over} !== {3'd7, 3'd0, 4'b0100, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wall_hit: got %0d,%0d,%b step=%b go=%b expected 7,0,0100 step=0 go=1",
               head_x, head_y, heading, step, game_over);
    end
    direction = 4'b1000;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (step !== 1'b0) saw = 1'b1;
    end
    direction = 4'b0000;
    checks++;
    if (saw || {head_x, head_y, heading, game_over} !== {3'd7, 3'd0, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL dead_frozen: got step_seen=%b %0d,%0d,%b go=%b expected 0 7,0,0100 go=1",
               saw, head_x, head_y, heading, game_over);
    end
`endif
  endtask

  task automatic test_reset_mid_step();
    bit   found;
    bit   saw;
    int   cyc;
    exp_t e;
    rst = 1'b1;
    direction = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    direction = 4'b0010;
    enable = 1'b1;
    sb.push_back(mk(5, 4, 4'b0010));
    wait_step(12, found, cyc);
    e = sb.pop_front();
    checks++;
    if (!found || cyc != 5 || {head_x, head_y, heading} !== e) begin
      errors++;
      $display("FAIL restart_step: got found=%b cycles=%0d %0d,%0d,%b expected cycles=5 %0d,%0d,%b",
               found, cyc, head_x, head_y, heading, e.x, e.y, e.hd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({head_x, head_y, heading, step, game_over} !== {3'd4, 3'd4, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %0d,%0d,%b step=%b go=%b expected 4,4,0000 step=0 go=0",
               head_x, head_y, heading, step, game_over);
    end
    @(negedge clk);
    rst = 1'b0;
    direction = 4'b0000;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (step !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw || {head_x, head_y} !== {3'd4, 3'd4}) begin
      errors++;
      $display("FAIL idle_after_reset: got step_seen=%b x=%0d y=%0d, expected 0 4 4", saw, head_x, head_y);
    end
    direction = 4'b0010;
    sb.push_back(mk(5, 4, 4'b0010));
    wait_step(12, found, cyc);
    e = sb.pop_front();
    checks++;
    if (!found || cyc != 5 || {head_x, head_y, heading} !== e) begin
      errors++;
      $display("FAIL restart_after_reset: got found=%b cycles=%0d %0d,%0d,%b expected cycles=5 %0d,%0d,%b",
               found, cyc, head_x, head_y, heading, e.x, e.y, e.hd);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_move_right();
    test_reversal();
    test_tick_collision();
    test_pause();
    test_wall();
    test_reset_mid_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
